// File: rtl/move_repeater.sv
// Debounced, auto-repeating direction-button front end. It times each interval with an
// external millisecond delay timer and hands moves downstream over valid/ready.
module move_repeater #(
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned FIRST_MS    = 250,
    parameter int unsigned REPEAT_MS   = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic       delay_free,
    output logic       delay_set,
    output logic [7:0] delay_ms,
    output logic       move_valid,
    output logic [1:0] move_dir,
    input  logic       move_ready
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DEB_WAIT  = 2'd1,
        ST_EMIT      = 2'd2,
        ST_HOLD_WAIT = 2'd3
    } state_t;

    localparam logic [7:0] C_DEB_MS    = 8'(DEBOUNCE_MS);
    localparam logic [7:0] C_FIRST_MS  = 8'(FIRST_MS);
    localparam logic [7:0] C_REPEAT_MS = 8'(REPEAT_MS);

    logic [3:0] r_sync1;
    logic [3:0] r_sbtn;
    state_t     r_state;
    logic [1:0] r_dir;
    logic       r_first;
    logic       r_delay_set;
    logic [7:0] r_delay_ms;
    logic       r_move_valid;
    logic [1:0] r_move_dir;

    logic w_held;
    logic w_free_ok;
    logic w_accept;

    // Lowest set index wins: up > right > down > left.
    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        if (v[0]) begin
            return 2'd0;
        end else if (v[1]) begin
            return 2'd1;
        end else if (v[2]) begin
            return 2'd2;
        end else begin
            return 2'd3;
        end
    endfunction

    // The timer has not yet dropped free in the cycle its load pulse is visible.
    assign w_held    = r_sbtn[r_dir];
    assign w_free_ok = delay_free & ~r_delay_set;
    assign w_accept  = r_move_valid & move_ready;

    // Two-flop synchroniser for the asynchronous buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 4'b0000;
            r_sbtn  <= 4'b0000;
        end else begin
            r_sync1 <= btn;
            r_sbtn  <= r_sync1;
        end
    end

    // Main state machine with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_dir        <= 2'd0;
            r_first      <= 1'b1;
            r_delay_set  <= 1'b0;
            r_delay_ms   <= 8'd0;
            r_move_valid <= 1'b0;
            r_move_dir   <= 2'd0;
        end else begin
            r_delay_set <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_sbtn != 4'b0000) begin
                        r_dir       <= lowest_set(r_sbtn);
                        r_delay_set <= 1'b1;
                        r_delay_ms  <= C_DEB_MS;
                        r_first     <= 1'b1;
                        r_state     <= ST_DEB_WAIT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DEB_WAIT, ST_HOLD_WAIT: begin
                    if (!w_held) begin
                        r_state <= ST_IDLE;
                    end else if (w_free_ok) begin
                        r_move_valid <= 1'b1;
                        r_move_dir   <= r_dir;
                        r_state      <= ST_EMIT;
                    end else begin
                        r_state <= r_state;
                    end
                end
                ST_EMIT: begin
                    // Valid stays up until accepted, regardless of the button.
                    if (w_accept) begin
                        r_move_valid <= 1'b0;
                        r_delay_set  <= 1'b1;
                        r_delay_ms   <= r_first ? C_FIRST_MS : C_REPEAT_MS;
                        r_first      <= 1'b0;
                        r_state      <= ST_HOLD_WAIT;
                    end else begin
                        r_state <= ST_EMIT;
                    end
                end
                default: begin
                    r_move_valid <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign delay_set  = r_delay_set;
    assign delay_ms   = r_delay_ms;
    assign move_valid = r_move_valid;
    assign move_dir   = r_move_dir;

endmodule
